// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side input fields with valid/ready, execute-side
// registered outputs with valid/ready, plus flush and occupancy.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid must not depend on ready, and ready never depends combinationally on valid.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_add;
    logic [DATA_W-1:0] in_dato1;
    logic [DATA_W-1:0] in_dato2;
    logic [DATA_W-1:0] in_extend;
    logic [REG_W-1:0]  in_b25_21;
    logic [REG_W-1:0]  in_b20_16;
    logic [REG_W-1:0]  in_b15_11;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;

    logic              ou_valid;
    logic              ou_ready;
    logic [DATA_W-1:0] ou_add;
    logic [DATA_W-1:0] ou_dato_1;
    logic [DATA_W-1:0] ou_dato_2;
    logic [DATA_W-1:0] ou_extend;
    logic [REG_W-1:0]  ou_b25_21;
    logic [REG_W-1:0]  ou_b20_16;
    logic [REG_W-1:0]  ou_b15_11;
    logic [CTRL_W-1:0] ou_ctrl;
    logic [1:0]        ou_occ;

    modport master (
        output in_valid, in_add, in_dato1, in_dato2, in_extend,
               in_b25_21, in_b20_16, in_b15_11, in_ctrl, flush, ou_ready,
        input  in_ready, ou_valid, ou_add, ou_dato_1, ou_dato_2, ou_extend,
               ou_b25_21, ou_b20_16, ou_b15_11, ou_ctrl, ou_occ
    );

    modport slave (
        input  in_valid, in_add, in_dato1, in_dato2, in_extend,
               in_b25_21, in_b20_16, in_b15_11, in_ctrl, flush, ou_ready,
        output in_ready, ou_valid, ou_add, ou_dato_1, ou_dato_2, ou_extend,
               ou_b25_21, ou_b20_16, ou_b15_11, ou_ctrl, ou_occ
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a main slot driving the outputs and a one-entry
// skid slot, so in_ready is a pure register and stalls never drop an instruction.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave stage_io
);

    typedef struct packed {
        logic [DATA_W-1:0] add;
        logic [DATA_W-1:0] dato1;
        logic [DATA_W-1:0] dato2;
        logic [DATA_W-1:0] extend;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;

    payload_t in_pl;
    logic     in_ready;
    logic     main_free;
    logic     accept;

    // Control is zeroed at capture when the slot is empty, so a bubble is a NOP.
    always_comb begin
        in_pl        = '0;
        in_pl.add    = stage_io.in_add;
        in_pl.dato1  = stage_io.in_dato1;
        in_pl.dato2  = stage_io.in_dato2;
        in_pl.extend = stage_io.in_extend;
        in_pl.rs     = stage_io.in_b25_21;
        in_pl.rt     = stage_io.in_b20_16;
        in_pl.rd     = stage_io.in_b15_11;
        in_pl.ctrl   = stage_io.in_valid ? stage_io.in_ctrl : '0;
    end

    assign in_ready  = rst_n & ~skid_valid_q;
    assign main_free = ~main_valid_q | stage_io.ou_ready;
    assign accept    = stage_io.in_valid & in_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (stage_io.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d.ctrl  = '0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_d       = in_pl;
                main_valid_d = stage_io.in_valid;
            end
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign stage_io.in_ready  = in_ready;
    assign stage_io.ou_valid  = main_valid_q;
    assign stage_io.ou_add    = main_q.add;
    assign stage_io.ou_dato_1 = main_q.dato1;
    assign stage_io.ou_dato_2 = main_q.dato2;
    assign stage_io.ou_extend = main_q.extend;
    assign stage_io.ou_b25_21 = main_q.rs;
    assign stage_io.ou_b20_16 = main_q.rt;
    assign stage_io.ou_b15_11 = main_q.rd;
    assign stage_io.ou_ctrl   = main_q.ctrl;
    assign stage_io.ou_occ    = 2'(main_valid_q) + 2'(skid_valid_q);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of per-cycle vectors plus hand sequences
// for reset, reset mid-stall and a wide-parameter pass-through instance.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CTRL_W(8))  bus ();
    id_ex_stage_if #(.DATA_W(64), .REG_W(6), .CTRL_W(12)) wbus ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stage_io (bus)
    );

    id_ex_stage #(.DATA_W(64), .REG_W(6), .CTRL_W(12)) u_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .stage_io (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_add;
        logic        ou_ready;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_add;
        logic [1:0]  exp_occ;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[$];

    // Side fields are derived from PC+4 so every field carries a distinct tag.
    function automatic logic [31:0] dato1_of(input logic [31:0] a);
        return a ^ 32'h1111_0000;
    endfunction
    function automatic logic [31:0] dato2_of(input logic [31:0] a);
        return a + 32'h0000_0100;
    endfunction
    function automatic logic [31:0] ext_of(input logic [31:0] a);
        return {16'hFFFF, a[15:0]};
    endfunction
    function automatic logic [4:0] rs_of(input logic [31:0] a);
        return a[6:2];
    endfunction
    function automatic logic [4:0] rt_of(input logic [31:0] a);
        return ~a[6:2];
    endfunction
    function automatic logic [4:0] rd_of(input logic [31:0] a);
        return a[6:2] ^ 5'h15;
    endfunction
    function automatic logic [7:0] ctrl_of(input logic [31:0] a);
        return {a[7:2], 2'b01};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_add    = a;
        bus.in_dato1  = dato1_of(a);
        bus.in_dato2  = dato2_of(a);
        bus.in_extend = ext_of(a);
        bus.in_b25_21 = rs_of(a);
        bus.in_b20_16 = rt_of(a);
        bus.in_b15_11 = rd_of(a);
        bus.in_ctrl   = ctrl_of(a);
        bus.ou_ready  = rdy;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.ou_valid), 64'd0);
        chk({tag, "_occ"},   64'(bus.ou_occ), 64'd0);
        chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_data"},  64'({bus.ou_add, bus.ou_dato_1}), 64'd0);
        chk({tag, "_data2"}, 64'({bus.ou_dato_2, bus.ou_extend}), 64'd0);
        chk({tag, "_idx"},   64'({bus.ou_b25_21, bus.ou_b20_16, bus.ou_b15_11, bus.ou_ctrl}), 64'd0);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.in_valid, v.in_add, v.ou_ready, v.flush);
        tick();
        chk({tag, "_valid"}, 64'(bus.ou_valid), 64'(v.exp_valid));
        chk({tag, "_occ"},   64'(bus.ou_occ), 64'(v.exp_occ));
        chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'(v.exp_in_ready));
        chk({tag, "_ctrl"},  64'(bus.ou_ctrl), v.exp_valid ? 64'(ctrl_of(v.exp_add)) : 64'd0);
        if (v.exp_valid) begin
            chk({tag, "_add"},   64'(bus.ou_add), 64'(v.exp_add));
            chk({tag, "_dato"},  64'({bus.ou_dato_1, bus.ou_dato_2}),
                64'({dato1_of(v.exp_add), dato2_of(v.exp_add)}));
            chk({tag, "_ext"},   64'(bus.ou_extend), 64'(ext_of(v.exp_add)));
            chk({tag, "_regs"},  64'({bus.ou_b25_21, bus.ou_b20_16, bus.ou_b15_11}),
                64'({rs_of(v.exp_add), rt_of(v.exp_add), rd_of(v.exp_add)}));
        end
    endtask

    task automatic add_vec(input logic v, input logic [31:0] a, input logic rdy, input logic fl,
                           input logic ev, input logic [31:0] ea, input logic [1:0] eo,
                           input logic eir);
        vec_t r;
        r.in_valid     = v;
        r.in_add       = a;
        r.ou_ready     = rdy;
        r.flush        = fl;
        r.exp_valid    = ev;
        r.exp_add      = ea;
        r.exp_occ      = eo;
        r.exp_in_ready = eir;
        vecs.push_back(r);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        wbus.in_valid  = 1'b0;
        wbus.in_add    = '0;
        wbus.in_dato1  = '0;
        wbus.in_dato2  = '0;
        wbus.in_extend = '0;
        wbus.in_b25_21 = '0;
        wbus.in_b20_16 = '0;
        wbus.in_b15_11 = '0;
        wbus.in_ctrl   = '0;
        wbus.flush     = 1'b0;
        wbus.ou_ready  = 1'b1;

        //        v    add     rdy  fl    ev   exp_add occ  in_rdy
        add_vec(1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h04, 2'd1, 1'b1); // release: first accept
        add_vec(1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 32'h08, 2'd1, 1'b1); // streaming
        add_vec(1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h0C, 2'd1, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1); // drain
        add_vec(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 2'd1, 1'b1); // stall with skid
        add_vec(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 1'b0);
        add_vec(1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 1'b0); // full holds
        add_vec(1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 2'd2, 1'b0);
        add_vec(1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h14, 2'd1, 1'b1); // skid -> main
        add_vec(1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h18, 2'd1, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b1, 32'h1C, 1'b1, 1'b0, 1'b1, 32'h1C, 2'd1, 1'b1); // flush when full
        add_vec(1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h1C, 2'd2, 1'b0);
        add_vec(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b1, 32'h28, 1'b1, 1'b0, 1'b1, 32'h28, 2'd1, 1'b1); // flush with ou_ready
        add_vec(1'b1, 32'h2C, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);
        add_vec(1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h30, 2'd1, 1'b1); // empty main is free
        add_vec(1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h30, 2'd1, 1'b1); // hold one entry
        add_vec(1'b1, 32'h34, 1'b0, 1'b0, 1'b1, 32'h30, 2'd2, 1'b0);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h34, 2'd1, 1'b1);
        add_vec(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1);

        // Reset held two edges with an instruction offered
        tick();
        tick();
        check_all_zero("rst_hold");

        rst_n = 1'b1;
        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Reset while full: both slots discarded, nothing stale after release
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        chk("midrst_pre_occ", 64'(bus.ou_occ), 64'd2);
        drive(1'b1, 32'h48, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        drive(1'b0, 32'h00, 1'b1, 1'b0);
        tick();
        chk("midrst_rel_valid", 64'(bus.ou_valid), 64'd0);
        chk("midrst_rel_occ",   64'(bus.ou_occ), 64'd0);
        tick();
        chk("midrst_rel2_valid", 64'(bus.ou_valid), 64'd0);
        drive(1'b1, 32'h4C, 1'b1, 1'b0);
        tick();
        chk("midrst_new_add", 64'(bus.ou_add), 64'h4C);
        chk("midrst_new_valid", 64'(bus.ou_valid), 64'd1);

        // Wide instance: bit-exact pass-through of every field
        wbus.in_valid  = 1'b1;
        wbus.in_add    = 64'h1234_5678_9ABC_DEF0;
        wbus.in_dato1  = 64'hDEAD_BEEF_0000_0001;
        wbus.in_dato2  = 64'h8000_0000_0000_0000;
        wbus.in_extend = 64'hFFFF_FFFF_FFFF_FFF0;
        wbus.in_b25_21 = 6'h21;
        wbus.in_b20_16 = 6'h2A;
        wbus.in_b15_11 = 6'h3F;
        wbus.in_ctrl   = 12'hABC;
        tick();
        chk("wide_valid",  64'(wbus.ou_valid), 64'd1);
        chk("wide_add",    wbus.ou_add, 64'h1234_5678_9ABC_DEF0);
        chk("wide_dato1",  wbus.ou_dato_1, 64'hDEAD_BEEF_0000_0001);
        chk("wide_dato2",  wbus.ou_dato_2, 64'h8000_0000_0000_0000);
        chk("wide_extend", wbus.ou_extend, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("wide_regs",   64'({wbus.ou_b25_21, wbus.ou_b20_16, wbus.ou_b15_11}),
            64'({6'h21, 6'h2A, 6'h3F}));
        chk("wide_ctrl",   64'(wbus.ou_ctrl), 64'hABC);
        wbus.in_valid = 1'b0;
        tick();
        chk("wide_bubble_ctrl", 64'(wbus.ou_ctrl), 64'd0);
        chk("wide_bubble_occ",  64'(wbus.ou_occ), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline stage register with valid/ready handshake, a one-entry skid buffer and synchronous flush. It sits between the decode stage (register file read, sign extend) and the execute stage of the MIPS pipeline. It replaces a free-running buffer with one that can stall without losing an instruction, and can insert bubbles on branch or hazard flush. Data width, register-index width and control-bundle width are parameters.

## Interface
- DATA_W, 32, width of PC+4, both register operands and sign-extended immediate
- REG_W, 5, width of register indices (rs, rt, rd)
- CTRL_W, 8, width of the opaque control bundle from the decoder; all-zero means NOP
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage can accept; equals NOT skid_valid; 0 while rst_n=0
- in_add  in  DATA_W  PC+4
- in_dato1, in_dato2  in  DATA_W  register file read data (rs, rt)
- in_extend  in  DATA_W  sign-extended immediate
- in_b25_21, in_b20_16, in_b15_11  in  REG_W  rs, rt, rd indices
- in_ctrl  in  CTRL_W  control bundle
- flush  in  1  discard all held instructions
- ou_valid  out  1  output fields hold a live instruction
- ou_ready  in  1  execute stage consumes the output this cycle
- ou_add, ou_dato_1, ou_dato_2, ou_extend  out  DATA_W  registered copies
- ou_b25_21, ou_b20_16, ou_b15_11  out  REG_W  registered copies
- ou_ctrl  out  CTRL_W  registered control; forced to 0 when ou_valid=0
- ou_occ  out  2  entries held (0, 1 or 2)

## Operation
- Two storage slots: main (drives outputs) and skid. Each has a valid bit.
- Accept: in_valid & in_ready. Main is free when !ou_valid | ou_ready.
- The following rules apply when flush=0 and rst_n=1, evaluated per rising edge:
  - Main free, skid_valid=1: main <= skid, skid_valid <= 0. There is no input accept, because in_ready=0.
  - Main free, skid_valid=0: main <= input fields, ou_valid <= in_valid.
  - Main not free, accept: skid <= input fields, skid_valid <= 1.
  - Main not free, no accept: hold.
- Flush=1: ou_valid <= 0, skid_valid <= 0, ou_ctrl <= 0. An input presented that cycle is dropped, even if in_ready=1. Other data fields hold their value and are don't-care.
- Flush has priority over every capture and transfer. It has lower priority than reset.
- ou_occ = ou_valid + skid_valid.
- Ordering is strictly FIFO. No instruction is duplicated or lost except by flush.
- Reset (rst_n=0 at an edge): all outputs, including every data field, become 0. ou_valid=0, skid_valid=0, ou_occ=0. Reset mid-stall discards both slots.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N and stays until the edge where ou_ready=1.
- Throughput is 1 per cycle while ou_ready=1. in_ready never deasserts in that case.
- in_ready falls 1 cycle after the first accept made while main is blocked. It rises 1 cycle after the edge that drains the skid.
- in_ready has no combinational path from ou_ready or in_valid, so the ready chain is cut. The output fields are registered.
- Boundaries:
  - Full: occ=2 and ou_ready=0. Holds indefinitely with no change.
  - Full with ou_ready=1: main takes the skid contents, occ becomes 1, in_ready=1 the next cycle.
  - Flush together with ou_ready=1: the output is considered consumed and the stage becomes empty.
  - Flush together with in_valid: the input is dropped and in_valid is not stored.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> all outputs 0, in_ready=0. Release with in_add=0x4, ou_ready=1 -> next cycle ou_valid=1, ou_add=0x4.
- Streaming: feed in_add=0x4,0x8,0xC on consecutive cycles with ou_ready=1 -> ou_add shows 0x4,0x8,0xC one cycle later, in_ready stays 1, ou_occ=1 throughout.
- Stall with skid: send 0x10 then 0x14, ou_ready=0 from the cycle after 0x10 appears -> ou_add=0x10 held, ou_occ=2, in_ready=0. Raise ou_ready -> ou_add=0x14 next cycle, in_ready=1.
- Flush when full: occ=2, assert flush for 1 cycle with in_valid=1, in_add=0x20 -> ou_valid=0, ou_ctrl=0, ou_occ=0, and 0x20 never appears.
- Widths: DATA_W=64, REG_W=6, CTRL_W=12, in_extend=0xFFFF_FFFF_FFFF_FFF0, in_b15_11=6'h3F -> values pass through bit-exact.
- Reset mid-stall: occ=2, drive rst_n=0 for one edge -> all outputs 0, occ=0, and no stale instruction appears after release.
